// File: rtl/operand_seq_pkg.sv
// Shared definitions for the operand sequencer: state encoding, default sizes
// and the memory depth derivation.
package operand_seq_pkg;

    localparam int DATA_WIDTH_DEF = 9;
    localparam int ADDR_WIDTH_DEF = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD_A = ST_LOAD_A,
        S_LOAD_B = ST_LOAD_B,
        S_RUN    = ST_RUN,
        S_DONE   = ST_DONE
    } seq_state_t;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/operand_sequencer.sv
// Loads multiplicand/multiplier pairs into a dual-bank operand memory and
// replays them in load order to the Booth multiplier on Start.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a pair, Start or Clr
// LOAD_A  | writing captured multiplicand to bank 1 at address Count
// LOAD_B  | writing captured multiplier to bank 2, Count increments
// RUN     | presenting pair at Ptr to the multiplier
// DONE    | one-cycle completion pulse
module operand_sequencer
    import operand_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [DATA_WIDTH-1:0] In_A,
    input  logic [DATA_WIDTH-1:0] In_B,
    input  logic                  Start,
    input  logic                  Clr,
    output logic                  Busy,
    output logic                  Done,
    output logic [ADDR_WIDTH:0]   Count,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic [DATA_WIDTH-1:0] Mem_Data_In,
    output logic                  Mem_W_En,
    output logic                  Mem_Sel,
    input  logic [DATA_WIDTH-1:0] Mem_Data1_I,
    input  logic [DATA_WIDTH-1:0] Mem_Data2_I,
    output logic                  Op_Valid,
    input  logic                  Op_Ready,
    output logic [DATA_WIDTH-1:0] Op_A,
    output logic [DATA_WIDTH-1:0] Op_B,
    output logic                  Op_Last
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    seq_state_t              state, state_nxt;
    logic [ADDR_WIDTH:0]     count_nxt;
    logic [ADDR_WIDTH:0]     Ptr, ptr_nxt;
    logic [DATA_WIDTH-1:0]   A_r, B_r, a_nxt, b_nxt;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
            Count <= '0;
            Ptr   <= '0;
            A_r   <= '0;
            B_r   <= '0;
        end else begin
            state <= state_nxt;
            Count <= count_nxt;
            Ptr   <= ptr_nxt;
            A_r   <= a_nxt;
            B_r   <= b_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        count_nxt   = Count;
        ptr_nxt     = Ptr;
        a_nxt       = A_r;
        b_nxt       = B_r;
        In_Ready    = 1'b0;
        Busy        = (state != S_IDLE);
        Done        = 1'b0;
        Mem_Addr    = '0;
        Mem_Data_In = '0;
        Mem_W_En    = 1'b0;
        Mem_Sel     = 1'b0;
        Op_Valid    = 1'b0;
        Op_A        = '0;
        Op_B        = '0;
        Op_Last     = 1'b0;

        unique case (state)
            S_IDLE: begin
                In_Ready = (Count < DEPTH_C) && !Start && !Clr;
                if (Clr) begin
                    count_nxt = '0;
                end else if (Start) begin
                    if (Count == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        ptr_nxt   = '0;
                        state_nxt = S_RUN;
                    end
                end else if (In_Valid && In_Ready) begin
                    a_nxt     = In_A;
                    b_nxt     = In_B;
                    state_nxt = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                Mem_W_En    = 1'b1;
                Mem_Addr    = Count[ADDR_WIDTH-1:0];
                Mem_Data_In = A_r;
                state_nxt   = S_LOAD_B;
            end
            S_LOAD_B: begin
                Mem_W_En    = 1'b1;
                Mem_Sel     = 1'b1;
                Mem_Addr    = Count[ADDR_WIDTH-1:0];
                Mem_Data_In = B_r;
                count_nxt   = Count + ONE_C;
                state_nxt   = S_IDLE;
            end
            S_RUN: begin
                // Read is combinational, so operands track Mem_Addr in the same cycle.
                Mem_Addr = Ptr[ADDR_WIDTH-1:0];
                Op_Valid = 1'b1;
                Op_A     = Mem_Data1_I;
                Op_B     = Mem_Data2_I;
                Op_Last  = (Ptr == Count - ONE_C);
                if (Op_Ready) begin
                    if (Op_Last) state_nxt = S_DONE;
                    else         ptr_nxt   = Ptr + ONE_C;
                end
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: behavioural pair list plus a
// simple dual-bank memory model beside the DUT.
module tb_operand_sequencer;

    localparam int DW    = 9;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          Clk = 1'b0;
    logic          Rst, In_Valid, Start, Clr, Op_Ready;
    logic [DW-1:0] In_A, In_B;
    logic          In_Ready, Busy, Done, Mem_W_En, Mem_Sel, Op_Valid, Op_Last;
    logic [AW:0]   Count;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_Data_In, Mem_Data1_I, Mem_Data2_I, Op_A, Op_B;

    logic [DW-1:0] bank1 [0:DEPTH-1];
    logic [DW-1:0] bank2 [0:DEPTH-1];
    logic [DW-1:0] exp_a [0:DEPTH-1];
    logic [DW-1:0] exp_b [0:DEPTH-1];
    int            mc;
    int            total = 0;
    int            bad   = 0;

    always #5 Clk = ~Clk;

    operand_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_A(In_A), .In_B(In_B), .Start(Start), .Clr(Clr), .Busy(Busy),
        .Done(Done), .Count(Count), .Mem_Addr(Mem_Addr), .Mem_Data_In(Mem_Data_In),
        .Mem_W_En(Mem_W_En), .Mem_Sel(Mem_Sel), .Mem_Data1_I(Mem_Data1_I),
        .Mem_Data2_I(Mem_Data2_I), .Op_Valid(Op_Valid), .Op_Ready(Op_Ready),
        .Op_A(Op_A), .Op_B(Op_B), .Op_Last(Op_Last)
    );

    always @(posedge Clk) begin
        if (Mem_W_En) begin
            if (Mem_Sel) bank2[Mem_Addr] <= Mem_Data_In;
            else         bank1[Mem_Addr] <= Mem_Data_In;
        end
    end
    assign Mem_Data1_I = bank1[Mem_Addr];
    assign Mem_Data2_I = bank2[Mem_Addr];

    task automatic test_reset();
        @(negedge Clk); Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk); Rst = 1'b0; #1;
        mc = 0;
        total++;
        if (In_Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0 || Count !== 5'd0) begin
            bad++;
            $display("FAIL reset_ctrl got rdy=%0b busy=%0b done=%0b cnt=%0d exp 1 0 0 0",
                     In_Ready, Busy, Done, Count);
        end
        total++;
        if (Mem_W_En !== 1'b0 || Op_Valid !== 1'b0 || Op_Last !== 1'b0 ||
            Mem_Addr !== 4'd0 || Mem_Data_In !== 9'd0 || Mem_Sel !== 1'b0) begin
            bad++;
            $display("FAIL reset_mem got we=%0b ov=%0b ol=%0b addr=%0d din=%0h sel=%0b exp all 0",
                     Mem_W_En, Op_Valid, Op_Last, Mem_Addr, Mem_Data_In, Mem_Sel);
        end
    endtask

    task automatic load_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge Clk); In_Valid = 1'b1; In_A = a; In_B = b; #1;
        total++;
        if (In_Ready !== 1'b1) begin
            bad++;
            $display("FAIL load_ready got=%0b exp=1", In_Ready);
        end
        @(negedge Clk); In_A = ~a; In_B = ~b; Start = 1'b1; #1;
        total++;
        if (In_Ready !== 1'b0 || Mem_W_En !== 1'b1 || Mem_Sel !== 1'b0 ||
            Mem_Addr !== mc[AW-1:0] || Mem_Data_In !== a || Busy !== 1'b1) begin
            bad++;
            $display("FAIL load_a got rdy=%0b we=%0b sel=%0b addr=%0d din=%0h exp 0 1 0 %0d %0h",
                     In_Ready, Mem_W_En, Mem_Sel, Mem_Addr, Mem_Data_In, mc, a);
        end
        @(negedge Clk); Start = 1'b0; #1;
        total++;
        if (In_Ready !== 1'b0 || Mem_W_En !== 1'b1 || Mem_Sel !== 1'b1 ||
            Mem_Addr !== mc[AW-1:0] || Mem_Data_In !== b) begin
            bad++;
            $display("FAIL load_b got rdy=%0b we=%0b sel=%0b addr=%0d din=%0h exp 0 1 1 %0d %0h",
                     In_Ready, Mem_W_En, Mem_Sel, Mem_Addr, Mem_Data_In, mc, b);
        end
        exp_a[mc] = a;
        exp_b[mc] = b;
        mc++;
        @(negedge Clk); In_Valid = 1'b0; #1;
        total++;
        if (In_Ready !== (mc < DEPTH) || Count !== mc[AW:0] || Busy !== 1'b0) begin
            bad++;
            $display("FAIL load_end got rdy=%0b cnt=%0d busy=%0b exp %0b %0d 0",
                     In_Ready, Count, Busy, mc < DEPTH, mc);
        end
    endtask

    // mode 0: Op_Ready always high, 1: stall 4 cycles on pair 1, 2: random Op_Ready
    task automatic run_replay(input int mode);
        int n, idx, cyc, stall_left;
        n = mc; idx = 0; cyc = 0; stall_left = 4;
        @(negedge Clk); Start = 1'b1; #1;
        total++;
        if (In_Ready !== 1'b0) begin
            bad++;
            $display("FAIL start_blocks_ready got=%0b exp=0", In_Ready);
        end
        @(negedge Clk); Start = 1'b0;
        while (idx < n && cyc < 200) begin
            case (mode)
                0: Op_Ready = 1'b1;
                1: if (idx == 1 && stall_left > 0) begin
                       Op_Ready = 1'b0;
                       stall_left--;
                   end else begin
                       Op_Ready = 1'b1;
                   end
                default: Op_Ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            total++;
            if (Op_Valid !== 1'b1 || Op_A !== exp_a[idx] || Op_B !== exp_b[idx] ||
                Op_Last !== (idx == n - 1) || Mem_Addr !== idx[AW-1:0] || Mem_W_En !== 1'b0) begin
                bad++;
                $display("FAIL replay_pair%0d got v=%0b a=%0h b=%0h last=%0b addr=%0d we=%0b exp 1 %0h %0h %0b %0d 0",
                         idx, Op_Valid, Op_A, Op_B, Op_Last, Mem_Addr, Mem_W_En,
                         exp_a[idx], exp_b[idx], idx == n - 1, idx);
            end
            if (Op_Ready) idx++;
            cyc++;
            @(negedge Clk);
        end
        Op_Ready = 1'b0;
        total++;
        if (idx != n) begin
            bad++;
            $display("FAIL replay_timeout got issued=%0d exp=%0d", idx, n);
        end
        if (mode == 0) begin
            total++;
            if (cyc != n) begin
                bad++;
                $display("FAIL replay_rate got cycles=%0d exp=%0d", cyc, n);
            end
        end
        #1;
        total++;
        if (Done !== 1'b1 || Op_Valid !== 1'b0 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL replay_done got done=%0b ov=%0b busy=%0b exp 1 0 1", Done, Op_Valid, Busy);
        end
        @(negedge Clk); #1;
        total++;
        if (Done !== 1'b0 || Busy !== 1'b0 || In_Ready !== (mc < DEPTH) || Count !== mc[AW:0]) begin
            bad++;
            $display("FAIL replay_after got done=%0b busy=%0b rdy=%0b cnt=%0d exp 0 0 %0b %0d",
                     Done, Busy, In_Ready, Count, mc < DEPTH, mc);
        end
    endtask

    task automatic do_clear();
        @(negedge Clk); Clr = 1'b1; #1;
        total++;
        if (In_Ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_ready got=%0b exp=0", In_Ready);
        end
        @(negedge Clk); Clr = 1'b0; #1;
        mc = 0;
        total++;
        if (Count !== 5'd0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL clr_count got cnt=%0d busy=%0b exp 0 0", Count, Busy);
        end
    endtask

    task automatic test_load_directed();
        load_pair(9'd3, 9'd5);
        load_pair(9'h1FE, 9'd7);
        load_pair(9'd255, 9'd1);
        total++;
        if (bank1[0] !== 9'd3 || bank1[1] !== 9'h1FE || bank1[2] !== 9'h0FF ||
            bank2[0] !== 9'd5 || bank2[1] !== 9'd7 || bank2[2] !== 9'd1) begin
            bad++;
            $display("FAIL bank_contents got b1=%0h,%0h,%0h b2=%0h,%0h,%0h exp 3,1fe,ff 5,7,1",
                     bank1[0], bank1[1], bank1[2], bank2[0], bank2[1], bank2[2]);
        end
    endtask

    task automatic test_random_load();
        int n;
        do_clear();
        n = $urandom_range(2, 9);
        for (int i = 0; i < n; i++) load_pair(DW'($urandom), DW'($urandom));
        run_replay(2);
    endtask

    task automatic test_full();
        do_clear();
        load_pair(9'h0A5, 9'h15A);
        for (int i = 1; i < DEPTH; i++) load_pair(DW'($urandom), DW'($urandom));
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); In_Valid = 1'b1; In_A = 9'h111; In_B = 9'h0EE; #1;
            total++;
            if (In_Ready !== 1'b0 || Mem_W_En !== 1'b0 || Busy !== 1'b0 || Count !== 5'd16) begin
                bad++;
                $display("FAIL full_block got rdy=%0b we=%0b busy=%0b cnt=%0d exp 0 0 0 16",
                         In_Ready, Mem_W_En, Busy, Count);
            end
        end
        @(negedge Clk); In_Valid = 1'b0; #1;
        total++;
        if (bank1[0] !== 9'h0A5 || bank2[0] !== 9'h15A) begin
            bad++;
            $display("FAIL full_no_wrap got b1=%0h b2=%0h exp a5 15a", bank1[0], bank2[0]);
        end
        run_replay(2);
    endtask

    task automatic test_start_empty();
        do_clear();
        run_replay(0);
    endtask

    task automatic test_start_clr_valid();
        load_pair(DW'($urandom), DW'($urandom));
        @(negedge Clk); Start = 1'b1; Clr = 1'b1; In_Valid = 1'b1; In_A = 9'h123; #1;
        total++;
        if (In_Ready !== 1'b0) begin
            bad++;
            $display("FAIL combo_ready got=%0b exp=0", In_Ready);
        end
        @(negedge Clk); Start = 1'b0; Clr = 1'b0; In_Valid = 1'b0; #1;
        mc = 0;
        total++;
        if (Count !== 5'd0 || Busy !== 1'b0 || Mem_W_En !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL combo_state got cnt=%0d busy=%0b we=%0b done=%0b exp 0 0 0 0",
                     Count, Busy, Mem_W_En, Done);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 3; i++) load_pair(DW'($urandom), DW'($urandom));
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0; Op_Ready = 1'b1;
        @(negedge Clk); Op_Ready = 1'b0; #1;
        total++;
        if (Op_Valid !== 1'b1 || Mem_Addr !== 4'd1 || Op_A !== exp_a[1]) begin
            bad++;
            $display("FAIL midrun_ptr got v=%0b addr=%0d a=%0h exp 1 1 %0h", Op_Valid, Mem_Addr, Op_A, exp_a[1]);
        end
        Rst = 1'b1;
        @(negedge Clk); Rst = 1'b0; #1;
        mc = 0;
        total++;
        if (Op_Valid !== 1'b0 || Count !== 5'd0 || Busy !== 1'b0 || In_Ready !== 1'b1) begin
            bad++;
            $display("FAIL midrun_reset got v=%0b cnt=%0d busy=%0b rdy=%0b exp 0 0 0 1",
                     Op_Valid, Count, Busy, In_Ready);
        end
        load_pair(9'h0C3, 9'h03C);
        total++;
        if (bank1[0] !== 9'h0C3 || bank2[0] !== 9'h03C) begin
            bad++;
            $display("FAIL reload_addr0 got b1=%0h b2=%0h exp c3 3c", bank1[0], bank2[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bank1[i] = '0; bank2[i] = '0; exp_a[i] = '0; exp_b[i] = '0;
        end
        Rst = 1'b1; In_Valid = 1'b0; Start = 1'b0; Clr = 1'b0; Op_Ready = 1'b0;
        In_A = '0; In_B = '0; mc = 0;
        test_reset();
        test_load_directed();
        run_replay(0);
        run_replay(1);
        test_random_load();
        test_full();
        test_start_empty();
        test_start_clr_valid();
        test_reset_mid_run();
        run_replay(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
